// File: rtl/sc_fifo_16x256_pkg.sv
// Shared constants, types and the occupancy-update helper for the 256 x 16 single-clock FIFO.
package sc_fifo_pkg;

  localparam int DATA_W             = 16;
  localparam int DEPTH              = 256;
  localparam int ADDR_W             = 8;
  localparam int ALMOST_FULL_VALUE  = 240;
  localparam int ALMOST_EMPTY_VALUE = 16;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ADDR_W-1:0] ptr_t;
  typedef logic [ADDR_W:0]   cnt_t;

  // A simultaneous accepted write and read leaves the occupancy unchanged.
  function automatic cnt_t next_count(input cnt_t cnt, input logic wr_ok, input logic rd_ok);
    cnt_t res;
    case ({wr_ok, rd_ok})
      2'b10:   res = cnt + cnt_t'(1);
      2'b01:   res = cnt - cnt_t'(1);
      default: res = cnt;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/sc_fifo_16x256_if.sv
// Producer/consumer bus of the FIFO. FIFO_ERR_FLAGS_EN adds the sticky overflow/underflow flags.
interface sc_fifo_16x256_if
  import sc_fifo_pkg::*;
  ();

  data_t data;
  logic  wrreq;
  logic  rdreq;
  data_t q;
  logic  full;
  logic  empty;
  logic  almost_full;
  logic  almost_empty;
  ptr_t  usedw;
`ifdef FIFO_ERR_FLAGS_EN
  logic  overflow;
  logic  underflow;

  modport master (
    output data, wrreq, rdreq,
    input  q, full, empty, almost_full, almost_empty, usedw, overflow, underflow
  );

  modport slave (
    input  data, wrreq, rdreq,
    output q, full, empty, almost_full, almost_empty, usedw, overflow, underflow
  );
`else
  modport master (
    output data, wrreq, rdreq,
    input  q, full, empty, almost_full, almost_empty, usedw
  );

  modport slave (
    input  data, wrreq, rdreq,
    output q, full, empty, almost_full, almost_empty, usedw
  );
`endif

endinterface

// File: rtl/sc_fifo_16x256_ram.sv
// Simple dual-port DEPTH x DATA_W storage with a registered, enabled read port.
// The read register doubles as the FIFO's q, so it is reset and cleared; the array is not.
module sc_fifo_ram
  import sc_fifo_pkg::*;
  (
    input  logic  clock,
    input  logic  Rst_n,
    input  logic  sclr,
    input  logic  i_we,
    input  ptr_t  i_waddr,
    input  data_t i_wdata,
    input  logic  i_re,
    input  ptr_t  i_raddr,
    output data_t o_rdata
  );

  data_t r_mem [DEPTH];
  data_t r_rdata;

  // Write port; contents are left untouched by reset and clear.
  always_ff @(posedge clock) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Registered read port; holds its value when no read is enabled.
  always_ff @(posedge clock or negedge Rst_n) begin
    if (!Rst_n) begin
      r_rdata <= '0;
    end else if (sclr) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end else begin
      r_rdata <= r_rdata;
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/sc_fifo_16x256.sv
// Single-clock 256 x 16 FIFO, normal (registered) read mode, registered status flags.
// Optional macro FIFO_ERR_FLAGS_EN adds sticky overflow/underflow outputs.
module sc_fifo_16x256
  import sc_fifo_pkg::*;
  #(
    parameter int AF_VALUE = ALMOST_FULL_VALUE,
    parameter int AE_VALUE = ALMOST_EMPTY_VALUE
  )
  (
    input logic              clock,
    input logic              Rst_n,
    input logic              sclr,
    sc_fifo_16x256_if.slave  fifo_if
  );

  ptr_t  r_wr_ptr;
  ptr_t  r_rd_ptr;
  cnt_t  r_cnt;
  logic  r_full;
  logic  r_empty;
  logic  r_almost_full;
  logic  r_almost_empty;
  ptr_t  r_usedw;

  logic  w_wr_ok;
  logic  w_rd_ok;
  cnt_t  w_cnt_nxt;
  data_t w_q;

  // Request acceptance and next occupancy; flags are registered from w_cnt_nxt.
  always_comb begin
    w_wr_ok   = fifo_if.wrreq && !r_full;
    w_rd_ok   = fifo_if.rdreq && !r_empty;
    w_cnt_nxt = next_count(r_cnt, w_wr_ok, w_rd_ok);
  end

  // Pointers, occupancy and status flags; sclr outranks any request.
  always_ff @(posedge clock or negedge Rst_n) begin
    if (!Rst_n) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_cnt          <= '0;
      r_full         <= 1'b0;
      r_empty        <= 1'b1;
      r_almost_full  <= 1'b0;
      r_almost_empty <= 1'b1;
      r_usedw        <= '0;
    end else if (sclr) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_cnt          <= '0;
      r_full         <= 1'b0;
      r_empty        <= 1'b1;
      r_almost_full  <= 1'b0;
      r_almost_empty <= 1'b1;
      r_usedw        <= '0;
    end else begin
      if (w_wr_ok) begin
        r_wr_ptr <= r_wr_ptr + ptr_t'(1);
      end else begin
        r_wr_ptr <= r_wr_ptr;
      end
      if (w_rd_ok) begin
        r_rd_ptr <= r_rd_ptr + ptr_t'(1);
      end else begin
        r_rd_ptr <= r_rd_ptr;
      end
      r_cnt          <= w_cnt_nxt;
      r_full         <= (w_cnt_nxt == cnt_t'(DEPTH));
      r_empty        <= (w_cnt_nxt == cnt_t'(0));
      r_almost_full  <= (w_cnt_nxt >= cnt_t'(AF_VALUE));
      r_almost_empty <= (w_cnt_nxt <  cnt_t'(AE_VALUE));
      r_usedw        <= w_cnt_nxt[ADDR_W-1:0];
    end
  end

  sc_fifo_ram u_ram (
    .clock   (clock),
    .Rst_n   (Rst_n),
    .sclr    (sclr),
    .i_we    (w_wr_ok && !sclr),
    .i_waddr (r_wr_ptr),
    .i_wdata (fifo_if.data),
    .i_re    (w_rd_ok && !sclr),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_q)
  );

  assign fifo_if.q            = w_q;
  assign fifo_if.full         = r_full;
  assign fifo_if.empty        = r_empty;
  assign fifo_if.almost_full  = r_almost_full;
  assign fifo_if.almost_empty = r_almost_empty;
  assign fifo_if.usedw        = r_usedw;

`ifdef FIFO_ERR_FLAGS_EN
  logic r_overflow;
  logic r_underflow;

  // Sticky error flags for requests that were refused.
  always_ff @(posedge clock or negedge Rst_n) begin
    if (!Rst_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (sclr) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= r_overflow  || (fifo_if.wrreq && r_full);
      r_underflow <= r_underflow || (fifo_if.rdreq && r_empty);
    end
  end

  assign fifo_if.overflow  = r_overflow;
  assign fifo_if.underflow = r_underflow;
`endif

endmodule

// File: tb/tb_sc_fifo_16x256.sv
// Directed self-checking bench for sc_fifo_16x256: fill/drain loops, a vector table for
// simultaneous read/write corners, sclr, and asynchronous reset (FIFO_ERR_FLAGS_EN optional).
module tb_sc_fifo_16x256;

  logic clock;
  logic Rst_n;
  logic sclr;
  int   n_checks;
  int   n_errors;

  sc_fifo_16x256_if u_if ();

  sc_fifo_16x256 u_dut (
    .clock   (clock),
    .Rst_n   (Rst_n),
    .sclr    (sclr),
    .fifo_if (u_if)
  );

  typedef struct {
    logic        wr;
    logic        rd;
    logic [15:0] din;
    logic [15:0] exp_q;
    logic [7:0]  exp_usedw;
    logic        exp_empty;
  } vec_t;

  vec_t vecs [16];

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    Rst_n = 1'b1;
    sclr = 1'b0;
    u_if.wrreq = 1'b0;
    u_if.rdreq = 1'b0;
    u_if.data = 16'h0000;

    // stored count 0, q holding 00FF after the drain below
    vecs[0]  = '{1'b1, 1'b0, 16'hA000, 16'h00FF, 8'd1, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 16'hA001, 16'h00FF, 8'd2, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 16'hA002, 16'h00FF, 8'd3, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 16'hA003, 16'h00FF, 8'd4, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 16'hA004, 16'h00FF, 8'd5, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 16'hA005, 16'hA000, 8'd5, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 16'hA006, 16'hA001, 8'd5, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 16'h0000, 16'hA002, 8'd4, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 16'h0000, 16'hA003, 8'd3, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 16'h0000, 16'hA004, 8'd2, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 16'h0000, 16'hA005, 8'd1, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 16'h0000, 16'hA006, 8'd0, 1'b1};
    vecs[12] = '{1'b1, 1'b1, 16'hB000, 16'hA006, 8'd1, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 16'h0000, 16'hB000, 8'd0, 1'b1};
    vecs[14] = '{1'b0, 1'b1, 16'h0000, 16'hB000, 8'd0, 1'b1};
    vecs[15] = '{1'b0, 1'b0, 16'h0000, 16'hB000, 8'd0, 1'b1};

    #3 Rst_n = 1'b0;
    repeat (2) @(negedge clock);
    Rst_n = 1'b1;
    repeat (20) step();
    chk("rst_empty", u_if.empty, 1);
    chk("rst_full", u_if.full, 0);
    chk("rst_usedw", u_if.usedw, 0);
    chk("rst_ae", u_if.almost_empty, 1);
    chk("rst_af", u_if.almost_full, 0);
    chk("rst_q", u_if.q, 0);

    for (int i = 0; i < 256; i++) begin
      u_if.wrreq = 1'b1;
      u_if.data = 16'(i);
      step();
      chk("fill_usedw", u_if.usedw, (i + 1) % 256);
      chk("fill_full", u_if.full, (i + 1 == 256));
      chk("fill_empty", u_if.empty, 0);
      chk("fill_af", u_if.almost_full, (i + 1 >= 240));
      chk("fill_ae", u_if.almost_empty, (i + 1 < 16));
    end
    u_if.data = 16'hDEAD;
    step();
    u_if.wrreq = 1'b0;
    chk("ovf_full", u_if.full, 1);
    chk("ovf_usedw", u_if.usedw, 0);
    chk("ovf_q", u_if.q, 0);
`ifdef FIFO_ERR_FLAGS_EN
    chk("ovf_flag", u_if.overflow, 1);
    chk("ovf_no_udf", u_if.underflow, 0);
`endif

    for (int i = 0; i < 256; i++) begin
      u_if.rdreq = 1'b1;
      step();
      chk("drain_q", u_if.q, i);
      chk("drain_usedw", u_if.usedw, 255 - i);
      chk("drain_empty", u_if.empty, (i == 255));
      chk("drain_full", u_if.full, 0);
      chk("drain_ae", u_if.almost_empty, (255 - i < 16));
      chk("drain_af", u_if.almost_full, (255 - i >= 240));
    end
    step();
    u_if.rdreq = 1'b0;
    chk("udf_q", u_if.q, 16'h00FF);
    chk("udf_empty", u_if.empty, 1);
`ifdef FIFO_ERR_FLAGS_EN
    chk("udf_flag", u_if.underflow, 1);
    chk("udf_ovf_held", u_if.overflow, 1);
`endif

    for (int v = 0; v < 16; v++) begin
      u_if.wrreq = vecs[v].wr;
      u_if.rdreq = vecs[v].rd;
      u_if.data = vecs[v].din;
      step();
      chk("vec_q", u_if.q, vecs[v].exp_q);
      chk("vec_usedw", u_if.usedw, vecs[v].exp_usedw);
      chk("vec_empty", u_if.empty, vecs[v].exp_empty);
      chk("vec_full", u_if.full, 0);
    end
    u_if.wrreq = 1'b0;
    u_if.rdreq = 1'b0;

    for (int i = 0; i < 100; i++) begin
      u_if.wrreq = 1'b1;
      u_if.data = 16'(16'h1000 + i);
      step();
    end
    u_if.wrreq = 1'b0;
    u_if.rdreq = 1'b1;
    step();
    u_if.rdreq = 1'b0;
    chk("pre_sclr_q", u_if.q, 16'h1000);
    u_if.wrreq = 1'b1;
    u_if.data = 16'h1100;
    step();
    chk("pre_sclr_usedw", u_if.usedw, 100);
    sclr = 1'b1;
    u_if.data = 16'hFFFF;
    step();
    sclr = 1'b0;
    u_if.wrreq = 1'b0;
    chk("sclr_usedw", u_if.usedw, 0);
    chk("sclr_empty", u_if.empty, 1);
    chk("sclr_q", u_if.q, 0);
    chk("sclr_ae", u_if.almost_empty, 1);
`ifdef FIFO_ERR_FLAGS_EN
    chk("sclr_ovf", u_if.overflow, 0);
    chk("sclr_udf", u_if.underflow, 0);
`endif
    u_if.wrreq = 1'b1;
    u_if.data = 16'h5A5A;
    step();
    u_if.wrreq = 1'b0;
    chk("post_sclr_usedw", u_if.usedw, 1);
    u_if.rdreq = 1'b1;
    step();
    u_if.rdreq = 1'b0;
    chk("post_sclr_q", u_if.q, 16'h5A5A);
    chk("post_sclr_empty", u_if.empty, 1);

    for (int i = 0; i < 3; i++) begin
      u_if.wrreq = 1'b1;
      u_if.data = 16'(16'h0C00 + i);
      step();
    end
    u_if.wrreq = 1'b0;
    u_if.rdreq = 1'b1;
    step();
    u_if.rdreq = 1'b0;
    chk("pre_arst_q", u_if.q, 16'h0C00);
    u_if.wrreq = 1'b1;
    u_if.data = 16'h0C10;
    #2 Rst_n = 1'b0;
    #1;
    chk("arst_q", u_if.q, 0);
    chk("arst_empty", u_if.empty, 1);
    chk("arst_usedw", u_if.usedw, 0);
    chk("arst_full", u_if.full, 0);
    chk("arst_ae", u_if.almost_empty, 1);
    chk("arst_af", u_if.almost_full, 0);
    u_if.wrreq = 1'b0;
    @(negedge clock);
    Rst_n = 1'b1;
    step();
    chk("post_arst_empty", u_if.empty, 1);
`ifdef FIFO_ERR_FLAGS_EN
    u_if.rdreq = 1'b1;
    step();
    u_if.rdreq = 1'b0;
    step();
    chk("udf_sticky", u_if.underflow, 1);
    chk("udf_no_ovf", u_if.overflow, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sc_fifo_16x256.md
Name: sc_fifo_16x256

Overview:
Single-clock, first-in first-out buffer: 256 words deep, 16 bits wide, normal (non-show-ahead) read mode. It has full, empty, almost-full and almost-empty flags, a fill-level count, and a synchronous clear. It sits between a producer and a consumer in the same clock domain, as a rate-smoothing buffer.

Parameters:
DATA_W, 16, data word width.
DEPTH, 256, number of storage words; must be a power of two.
ADDR_W, 8, log2(DEPTH); also the width of usedw.
ALMOST_FULL_VALUE, 240, almost_full asserts when the stored count is >= this value.
ALMOST_EMPTY_VALUE, 16, almost_empty asserts when the stored count is < this value.

Ports:
clock  in  1  system clock; all logic on the rising edge.
Rst_n  in  1  asynchronous active-low reset.
sclr  in  1  synchronous clear, active high.
data  in  DATA_W  write data.
wrreq  in  1  write request.
rdreq  in  1  read request.
q  out  DATA_W  read data, registered.
full  out  1  FIFO holds DEPTH words.
empty  out  1  FIFO holds 0 words.
almost_full  out  1  count >= ALMOST_FULL_VALUE.
almost_empty  out  1  count < ALMOST_EMPTY_VALUE.
usedw  out  ADDR_W  count modulo DEPTH.

Behaviour:
- One clock domain. Reset is asynchronous and active-low (Rst_n).
- Reset state, applied immediately when Rst_n goes low:
  - write pointer, read pointer and internal count = 0;
  - q = 0, empty = 1, full = 0, usedw = 0;
  - almost_empty = 1, almost_full = 0.
- Internal count is ADDR_W+1 bits, range 0..DEPTH.
- Write acceptance: wr_ok = wrreq && !full.
  - When accepted, data is stored at the write pointer and the write pointer increments, wrapping mod DEPTH.
  - A write while full is dropped; no state changes.
- Read acceptance: rd_ok = rdreq && !empty.
  - When accepted, the word at the read pointer is loaded into q at that same clock edge, so q is valid one cycle after rdreq is sampled. The read pointer then increments, wrapping mod DEPTH.
  - A read while empty is ignored and q holds its value.
  - q holds its value whenever no read is accepted.
- Count update per cycle:
  - wr_ok only: count + 1.
  - rd_ok only: count - 1.
  - both: count unchanged. Pointers both advance; the read returns the old head.
  - When full, only the read is accepted (write dropped). When empty, only the write is accepted; there is no fall-through.
- Flags are registered and derived from the next count, so they are valid in the cycle after the causing edge:
  - full = (count == DEPTH);
  - empty = (count == 0);
  - almost_full = (count >= ALMOST_FULL_VALUE);
  - almost_empty = (count < ALMOST_EMPTY_VALUE);
  - usedw = count[ADDR_W-1:0], which reads 0 when full; full disambiguates.
- sclr: synchronous clear with priority over wrreq and rdreq in the same cycle. It returns every register to its reset value, including q = 0. Memory contents need not be cleared.
- Storage has no read-during-write hazard: the read pointer never equals the write pointer while the FIFO is non-empty and being written. The RAM uses a registered read port.

Optional Feature:
FIFO_ERR_FLAGS_EN.
- Defined: adds outputs overflow and underflow (1 bit each).
  - overflow is a sticky flag set on the cycle after wrreq && full.
  - underflow is a sticky flag set on the cycle after rdreq && empty.
  - Both are cleared by Rst_n or sclr.
- Undefined: these ports and their logic are absent; the rest of the behaviour is identical.

Decomposition:
- Package sc_fifo_pkg holds:
  - constants DATA_W=16, DEPTH=256, ADDR_W=8;
  - default almost thresholds;
  - typedef data_t (logic [DATA_W-1:0]);
  - typedef ptr_t (logic [ADDR_W-1:0]);
  - typedef cnt_t (logic [ADDR_W:0]).
- One sub-module, sc_fifo_ram: a simple dual-port DEPTH x DATA_W RAM with a write port and a registered read port with read enable. Pointers, count and flags stay in the top level.

Test Plan:
- Reset, then idle 20 cycles -> empty=1, full=0, usedw=0, almost_empty=1, almost_full=0, q=0.
- Write 0..255 on consecutive cycles, no read -> usedw counts 1..255, then 0 with full=1 after the 256th write. almost_full rises after the 240th write; almost_empty falls after the 16th write. A further wrreq while full changes nothing.
- Then read 256 consecutive cycles -> q = 0,1,...,255, each one cycle after its rdreq. empty=1 after the last read. almost_empty rises when the count reaches 15. An extra rdreq while empty leaves q = 255.
- Simultaneous wrreq and rdreq with count = 5 -> count stays 5, order preserved. With count = 0 -> write only, and q is unchanged that cycle.
- sclr asserted with count = 100 and wrreq = 1 -> next cycle: count=0, empty=1, q=0. A subsequent write then read returns the new word.
- Rst_n pulsed low mid-burst, asynchronously between clock edges -> outputs go to reset values immediately, without waiting for a clock edge. With FIFO_ERR_FLAGS_EN, overflow/underflow set and hold after an illegal request and clear on sclr.
